// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC/divider widths, FSM state type and divider bit-counter width.
package mac_pkg;
  localparam int DW = 10;
  localparam int VW = 4;
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result valid-ready bus; master drives operands and out_ready, slave returns results.
interface seq_divider_if;
  import mac_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic div_by_zero;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring iteration; pr/din/divisor in, pr_next and quotient bit q out.
module div_step
  import mac_pkg::*;
(
  input  logic [VW:0]   pr,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_next,
  output logic          q
);
  logic [VW+1:0] sh, trial;
  // One extra bit of headroom so the borrow lands in the MSB.
  assign sh = {pr, din};
  assign trial = sh - {2'b00, divisor};
  assign q = ~trial[VW+1];
  assign pr_next = q ? trial[VW:0] : sh[VW:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock; ports clk, rst (async high), bus (slave).
module seq_divider
  import mac_pkg::*;
(
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  state_t state;
  logic [DW-1:0] sr;
  logic [VW-1:0] dr;
  logic [VW:0] pr, pr_next;
  logic [CW-1:0] cnt;
  logic q, zero;
  div_step u_step (.pr(pr), .din(sr[DW-1]), .divisor(dr), .pr_next(pr_next), .q(q));
  // A zero divisor still spends one BUSY cycle so its result appears one cycle after accept.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      dr <= '0;
      pr <= '0;
      cnt <= '0;
      zero <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          sr <= bus.dividend;
          dr <= bus.divisor;
          pr <= '0;
          cnt <= '0;
          zero <= bus.divisor == '0;
          bus.in_ready <= 1'b0;
          bus.div_by_zero <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          sr <= {sr[DW-2:0], q};
          pr <= pr_next;
          cnt <= cnt + 1'b1;
          if (zero || cnt == CW'(DW - 1)) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.quotient <= zero ? '1 : {sr[DW-2:0], q};
            bus.remainder <= zero ? '0 : pr_next[VW-1:0];
            bus.div_by_zero <= zero;
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  seq_divider_if bus ();
  seq_divider dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept(input int dd, input int dv);
    bus.in_valid = 1'b1;
    bus.dividend = 10'(dd);
    bus.divisor = 4'(dv);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 10'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%0b vld=%0b q=%0d r=%0d z=%0b want 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    accept(1000, 13);
    wait_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL basic_latency got %0d want 10", lat); end
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {10'd76, 4'd12, 1'b0}) begin
      bad++;
      $display("FAIL basic_1000_13 got q=%0d r=%0d z=%0b want 76 12 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 10'd225;
    bus.divisor = 4'd15;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_ready got %0b want 0", bus.in_ready); end
      tick();
    end
    wait_valid(lat);
    total++;
    if ({bus.quotient, bus.remainder} !== {10'd15, 4'd0}) begin
      bad++;
      $display("FAIL b2b_225_15 got q=%0d r=%0d want 15 0", bus.quotient, bus.remainder);
    end
    bus.dividend = 10'd1023;
    bus.divisor = 4'd1;
    tick();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_after_R got vld=%0b rdy=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept_R1 got rdy=%0b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    wait_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL b2b_latency got %0d want 10", lat); end
    total++;
    if ({bus.quotient, bus.remainder} !== {10'd1023, 4'd0}) begin
      bad++;
      $display("FAIL b2b_1023_1 got q=%0d r=%0d want 1023 0", bus.quotient, bus.remainder);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_small_and_zero();
    int lat;
    accept(5, 15);
    wait_valid(lat);
    total++;
    if ({bus.quotient, bus.remainder} !== {10'd0, 4'd5}) begin
      bad++;
      $display("FAIL small_5_15 got q=%0d r=%0d want 0 5", bus.quotient, bus.remainder);
    end
    drain();
    accept(7, 0);
    wait_valid(lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL zero_latency got %0d want 1", lat); end
    total++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {10'd1023, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL zero_7_0 got q=%0d r=%0d z=%0b want 1023 0 1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    accept(100, 7);
    total++;
    if (bus.div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_cleared got %0b want 0", bus.div_by_zero); end
    wait_valid(lat);
    bus.in_valid = 1'b1;
    bus.dividend = 10'd50;
    bus.divisor = 4'd5;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !== {1'b1, 1'b0, 10'd14, 4'd2}) begin
        bad++;
        $display("FAIL bp_hold got vld=%0b rdy=%0b q=%0d r=%0d want 1 0 14 2", bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_after_R got vld=%0b rdy=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    total++;
    if ({lat[7:0], bus.quotient, bus.remainder} !== {8'd10, 10'd10, 4'd0}) begin
      bad++;
      $display("FAIL bp_next_50_5 got lat=%0d q=%0d r=%0d want 10 10 0", lat, bus.quotient, bus.remainder);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    int lat;
    accept(999, 9);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 10'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got rdy=%0b vld=%0b q=%0d r=%0d z=%0b want 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick();
    rst = 1'b0;
    accept(999, 9);
    wait_valid(lat);
    total++;
    if ({lat[7:0], bus.quotient, bus.remainder} !== {8'd10, 10'd111, 4'd0}) begin
      bad++;
      $display("FAIL post_reset_999_9 got lat=%0d q=%0d r=%0d want 10 111 0", lat, bus.quotient, bus.remainder);
    end
    drain();
  endtask

  task automatic test_sweep();
    int lat, dd, dv, q, r;
    bit ok;
    for (int i = 0; i < 2000; i++) begin
      dv = i % 16;
      dd = i < 16 ? 1023 : i < 32 ? 0 : int'($urandom_range(0, 1023));
      accept(dd, dv);
      wait_valid(lat);
      q = int'(bus.quotient);
      r = int'(bus.remainder);
      ok = dv == 0 ? (q == 1023 && r == 0 && bus.div_by_zero === 1'b1 && lat == 1)
                   : (q * dv + r == dd && r < dv && bus.div_by_zero === 1'b0 && lat == 10);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL sweep %0d/%0d got q=%0d r=%0d z=%0b lat=%0d", dd, dv, q, r, bus.div_by_zero, lat);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_small_and_zero();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
